// File: rtl/store_narrow_if.sv
// Store-unit request/memory bundle between the MEM control FSM, store_narrow and data memory.
// Latency: none (wires only).
// Backpressure: memory stalls the unit by withholding o/i_StoreNarrow_mem_ack.
// Ports: request (start/addr/data/size), status (busy/done/err), memory (mem_*).
interface store_narrow_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_StoreNarrow_start;
    logic [ADDR_W-1:0] i_StoreNarrow_addr;
    logic [DATA_W-1:0] i_StoreNarrow_data;
    logic [1:0]        i_StoreNarrow_size;
    logic              o_StoreNarrow_busy;
    logic              o_StoreNarrow_done;
    logic              o_StoreNarrow_err;
    logic [ADDR_W-1:0] o_StoreNarrow_mem_addr;
    logic              o_StoreNarrow_mem_rd;
    logic              o_StoreNarrow_mem_wr;
    logic [DATA_W-1:0] o_StoreNarrow_mem_wdata;
    logic [DATA_W-1:0] i_StoreNarrow_mem_rdata;
    logic              i_StoreNarrow_mem_ack;

    // Requester + memory side.
    modport master (
        output i_StoreNarrow_start, i_StoreNarrow_addr, i_StoreNarrow_data, i_StoreNarrow_size,
        output i_StoreNarrow_mem_rdata, i_StoreNarrow_mem_ack,
        input  o_StoreNarrow_busy, o_StoreNarrow_done, o_StoreNarrow_err,
        input  o_StoreNarrow_mem_addr, o_StoreNarrow_mem_rd, o_StoreNarrow_mem_wr,
        input  o_StoreNarrow_mem_wdata
    );

    // Store unit side.
    modport slave (
        input  i_StoreNarrow_start, i_StoreNarrow_addr, i_StoreNarrow_data, i_StoreNarrow_size,
        input  i_StoreNarrow_mem_rdata, i_StoreNarrow_mem_ack,
        output o_StoreNarrow_busy, o_StoreNarrow_done, o_StoreNarrow_err,
        output o_StoreNarrow_mem_addr, o_StoreNarrow_mem_rd, o_StoreNarrow_mem_wr,
        output o_StoreNarrow_mem_wdata
    );
endinterface

// File: rtl/store_narrow.sv
// Narrowing store unit: byte/half via read-modify-write, word via direct write, into word-addressed memory.
// Latency start->done: word 2, byte/half 4, error 1 cycle; each ack wait cycle adds 1.
// Backpressure: rd/wr and address/data held stable until mem_ack; start ignored while busy.
// Ports: i_StoreNarrow_clk, i_StoreNarrow_rst_n (sync, active-low), bus (store_narrow_if.slave).
module store_narrow #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic           i_StoreNarrow_clk,
    input  logic           i_StoreNarrow_rst_n,
    store_narrow_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_MERGE = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_size;
    logic              r_err;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] r_wdata;
    logic              w_bad;
    logic [DATA_W-1:0] w_merged;

    // Illegal size or misaligned half/word is rejected without touching memory.
    always_comb begin
        w_bad = 1'b0;
        case (bus.i_StoreNarrow_size)
            2'b01:   w_bad = bus.i_StoreNarrow_addr[0];
            2'b10:   w_bad = (bus.i_StoreNarrow_addr[1:0] != 2'b00);
            2'b11:   w_bad = 1'b1;
            default: w_bad = 1'b0;
        endcase
    end

    // Replace only the addressed lanes of the word read back from memory.
    always_comb begin
        w_merged = r_rdata;
        if (r_size == 2'b00)
            w_merged[{r_addr[1:0], 3'b000} +: 8] = r_data[7:0];
        else if (r_size == 2'b01)
            w_merged[{r_addr[1], 4'b0000} +: 16] = r_data[15:0];
    end

    always_ff @(posedge i_StoreNarrow_clk) begin
        if (!i_StoreNarrow_rst_n) r_state <= S_IDLE;
        else                      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.i_StoreNarrow_start) begin
                    if (w_bad)                              w_next = S_DONE;
                    else if (bus.i_StoreNarrow_size == 2'b10) w_next = S_WRITE;
                    else                                    w_next = S_READ;
                end
            end
            S_READ:  if (bus.i_StoreNarrow_mem_ack) w_next = S_MERGE;
            S_MERGE: w_next = S_WRITE;
            S_WRITE: if (bus.i_StoreNarrow_mem_ack) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_StoreNarrow_clk) begin
        if (!i_StoreNarrow_rst_n) begin
            r_addr  <= '0;
            r_data  <= '0;
            r_size  <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.i_StoreNarrow_start) begin
                        r_addr  <= bus.i_StoreNarrow_addr;
                        r_data  <= bus.i_StoreNarrow_data;
                        r_size  <= bus.i_StoreNarrow_size;
                        r_err   <= w_bad;
                        // Word stores write the register value as-is; narrow stores overwrite this in MERGE.
                        r_wdata <= bus.i_StoreNarrow_data;
                    end
                end
                S_READ:  if (bus.i_StoreNarrow_mem_ack) r_rdata <= bus.i_StoreNarrow_mem_rdata;
                S_MERGE: r_wdata <= w_merged;
                default: ;
            endcase
        end
    end

    // All outputs decode from registered state, so they cannot change while an ack is pending.
    assign bus.o_StoreNarrow_busy      = (r_state != S_IDLE);
    assign bus.o_StoreNarrow_done      = (r_state == S_DONE);
    assign bus.o_StoreNarrow_err       = (r_state == S_DONE) && r_err;
    assign bus.o_StoreNarrow_mem_rd    = (r_state == S_READ);
    assign bus.o_StoreNarrow_mem_wr    = (r_state == S_WRITE);
    assign bus.o_StoreNarrow_mem_addr  = {r_addr[ADDR_W-1:2], 2'b00};
    assign bus.o_StoreNarrow_mem_wdata = r_wdata;
endmodule

// File: tb/tb_store_narrow.sv
module tb_store_narrow;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    store_narrow_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    store_narrow #(.ADDR_W(32), .DATA_W(32)) dut (
        .i_StoreNarrow_clk   (clk),
        .i_StoreNarrow_rst_n (rst_n),
        .bus                 (bus)
    );

    wire        busy  = bus.o_StoreNarrow_busy;
    wire        done  = bus.o_StoreNarrow_done;
    wire        err   = bus.o_StoreNarrow_err;
    wire        rd    = bus.o_StoreNarrow_mem_rd;
    wire        wr    = bus.o_StoreNarrow_mem_wr;
    wire [31:0] maddr = bus.o_StoreNarrow_mem_addr;
    wire [31:0] wdata = bus.o_StoreNarrow_mem_wdata;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Memory responder / monitor state
    logic [31:0] mem [logic [31:0]];
    int rd_wait = 0, wr_wait = 0, wcnt = 0;
    int rd_cyc = 0, wr_cyc = 0, rd_ack_cnt = 0, wr_ack_cnt = 0;
    int overlap = 0, stab_err = 0, done_cnt = 0;
    logic prev_rd = 0, prev_wr = 0, prev_ack = 0;
    logic [31:0] prev_addr = 0, prev_wdata = 0;

    always @(negedge clk) begin
        if (rd && wr) overlap++;
        if (rd) rd_cyc++;
        if (wr) wr_cyc++;
        if (done) done_cnt++;
        if (rd && prev_rd && !prev_ack && maddr !== prev_addr) stab_err++;
        if (wr && prev_wr && !prev_ack && (maddr !== prev_addr || wdata !== prev_wdata)) stab_err++;
        bus.i_StoreNarrow_mem_ack = 1'b0;
        if (rd || wr) begin
            if (wcnt >= (rd ? rd_wait : wr_wait)) begin
                bus.i_StoreNarrow_mem_ack = 1'b1;
                wcnt = 0;
                if (rd) begin
                    bus.i_StoreNarrow_mem_rdata = mem.exists(maddr) ? mem[maddr] : 32'h0;
                    rd_ack_cnt++;
                end else begin
                    mem[maddr] = wdata;
                    wr_ack_cnt++;
                end
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
        prev_rd = rd; prev_wr = wr; prev_ack = bus.i_StoreNarrow_mem_ack;
        prev_addr = maddr; prev_wdata = wdata;
    end

    // Issue one store and wait for done; optionally pulse start with junk while busy.
    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                            input bit poke, output int lat, output logic e);
        bus.i_StoreNarrow_start = 1'b1;
        bus.i_StoreNarrow_addr  = a;
        bus.i_StoreNarrow_data  = d;
        bus.i_StoreNarrow_size  = s;
        @(posedge clk); #1;
        bus.i_StoreNarrow_start = 1'b0;
        lat = -1;
        e = 1'bx;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = n;
                e = err;
                break;
            end
            if (poke) begin
                bus.i_StoreNarrow_start = ~bus.i_StoreNarrow_start;
                bus.i_StoreNarrow_addr  = 32'h200;
                bus.i_StoreNarrow_data  = 32'hFFFFFFFF;
                bus.i_StoreNarrow_size  = 2'b00;
            end
        end
        bus.i_StoreNarrow_start = 1'b0;
        if (lat < 0) begin
            total_cnt++;
            $display("FAIL store_timeout addr=%h: no done within 40 cycles (required done)", a);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total_cnt++; if (busy  !== 1'b0)  $display("FAIL reset_busy got %b want 0", busy);  else pass_cnt++;
        total_cnt++; if (done  !== 1'b0)  $display("FAIL reset_done got %b want 0", done);  else pass_cnt++;
        total_cnt++; if (err   !== 1'b0)  $display("FAIL reset_err got %b want 0", err);    else pass_cnt++;
        total_cnt++; if (rd    !== 1'b0)  $display("FAIL reset_rd got %b want 0", rd);      else pass_cnt++;
        total_cnt++; if (wr    !== 1'b0)  $display("FAIL reset_wr got %b want 0", wr);      else pass_cnt++;
        total_cnt++; if (maddr !== 32'h0) $display("FAIL reset_addr got %h want 0", maddr); else pass_cnt++;
        total_cnt++; if (wdata !== 32'h0) $display("FAIL reset_wdata got %h want 0", wdata); else pass_cnt++;
        rst_n = 1'b1;
    endtask

    task automatic test_byte();
        int lat; logic e; int r0, w0;
        mem[32'h100] = 32'h11223344;
        r0 = rd_ack_cnt; w0 = wr_ack_cnt;
        @(negedge clk);
        do_store(32'h101, 32'hAABBCCDD, 2'b00, 0, lat, e);
        @(posedge clk); #1;
        total_cnt++; if (lat !== 4) $display("FAIL byte_latency got %0d want 4", lat); else pass_cnt++;
        total_cnt++; if (e !== 1'b0) $display("FAIL byte_err got %b want 0", e); else pass_cnt++;
        total_cnt++; if (mem[32'h100] !== 32'h1122DD44) $display("FAIL byte_mem got %h want 1122dd44", mem[32'h100]); else pass_cnt++;
        total_cnt++; if (rd_ack_cnt - r0 !== 1) $display("FAIL byte_reads got %0d want 1", rd_ack_cnt - r0); else pass_cnt++;
        total_cnt++; if (wr_ack_cnt - w0 !== 1) $display("FAIL byte_writes got %0d want 1", wr_ack_cnt - w0); else pass_cnt++;
    endtask

    task automatic test_half();
        int lat; logic e;
        mem[32'h100] = 32'h11223344;
        @(negedge clk);
        do_store(32'h102, 32'h0000BEEF, 2'b01, 0, lat, e);
        @(posedge clk); #1;
        total_cnt++; if (lat !== 4) $display("FAIL half_latency got %0d want 4", lat); else pass_cnt++;
        total_cnt++; if (mem[32'h100] !== 32'hBEEF3344) $display("FAIL half_mem got %h want beef3344", mem[32'h100]); else pass_cnt++;
    endtask

    task automatic test_word();
        int lat; logic e; int rc0, w0;
        mem[32'h104] = 32'h0;
        rc0 = rd_cyc; w0 = wr_ack_cnt;
        @(negedge clk);
        do_store(32'h104, 32'hDEADBEEF, 2'b10, 0, lat, e);
        @(posedge clk); #1;
        total_cnt++; if (lat !== 2) $display("FAIL word_latency got %0d want 2", lat); else pass_cnt++;
        total_cnt++; if (e !== 1'b0) $display("FAIL word_err got %b want 0", e); else pass_cnt++;
        total_cnt++; if (mem[32'h104] !== 32'hDEADBEEF) $display("FAIL word_mem got %h want deadbeef", mem[32'h104]); else pass_cnt++;
        total_cnt++; if (rd_cyc - rc0 !== 0) $display("FAIL word_no_read got %0d rd cycles want 0", rd_cyc - rc0); else pass_cnt++;
        total_cnt++; if (wr_ack_cnt - w0 !== 1) $display("FAIL word_writes got %0d want 1", wr_ack_cnt - w0); else pass_cnt++;
    endtask

    task automatic test_errors();
        logic [31:0] ea [3] = '{32'h103, 32'h106, 32'h100};
        logic [1:0]  es [3] = '{2'b01, 2'b10, 2'b11};
        int lat; logic e; int acc0;
        acc0 = rd_cyc + wr_cyc;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            do_store(ea[i], 32'h12345678, es[i], 0, lat, e);
            total_cnt++; if (lat !== 1) $display("FAIL err%0d_latency got %0d want 1", i, lat); else pass_cnt++;
            total_cnt++; if (e !== 1'b1) $display("FAIL err%0d_flag got %b want 1", i, e); else pass_cnt++;
        end
        @(posedge clk); #1;
        total_cnt++; if (rd_cyc + wr_cyc - acc0 !== 0) $display("FAIL err_no_access got %0d rd/wr cycles want 0", rd_cyc + wr_cyc - acc0); else pass_cnt++;
    endtask

    task automatic test_wait();
        int lat; logic e; int s0, r0, w0;
        rd_wait = 3; wr_wait = 2;
        mem[32'h100] = 32'h11223344;
        mem[32'h200] = 32'hCAFEF00D;
        s0 = stab_err; r0 = rd_ack_cnt; w0 = wr_ack_cnt;
        @(negedge clk);
        do_store(32'h100, 32'h00000055, 2'b00, 1, lat, e);
        @(posedge clk); #1;
        rd_wait = 0; wr_wait = 0;
        total_cnt++; if (lat !== 9) $display("FAIL wait_latency got %0d want 9", lat); else pass_cnt++;
        total_cnt++; if (mem[32'h100] !== 32'h11223355) $display("FAIL wait_mem got %h want 11223355", mem[32'h100]); else pass_cnt++;
        total_cnt++; if (mem[32'h200] !== 32'hCAFEF00D) $display("FAIL wait_ignored_start got %h want cafef00d", mem[32'h200]); else pass_cnt++;
        total_cnt++; if (stab_err - s0 !== 0) $display("FAIL wait_stable got %0d changes want 0", stab_err - s0); else pass_cnt++;
        total_cnt++; if (rd_ack_cnt - r0 !== 1) $display("FAIL wait_reads got %0d want 1", rd_ack_cnt - r0); else pass_cnt++;
        total_cnt++; if (wr_ack_cnt - w0 !== 1) $display("FAIL wait_writes got %0d want 1", wr_ack_cnt - w0); else pass_cnt++;
        repeat (3) @(negedge clk);
        total_cnt++; if (busy !== 1'b0) $display("FAIL wait_idle_after got busy=%b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int lat; logic e; int d0;
        rd_wait = 5;
        mem[32'h100] = 32'h11223344;
        d0 = done_cnt;
        @(negedge clk);
        bus.i_StoreNarrow_start = 1'b1;
        bus.i_StoreNarrow_addr  = 32'h103;
        bus.i_StoreNarrow_data  = 32'h00000077;
        bus.i_StoreNarrow_size  = 2'b00;
        @(posedge clk); #1;
        bus.i_StoreNarrow_start = 1'b0;
        @(negedge clk);
        total_cnt++; if (rd !== 1'b1) $display("FAIL rstmid_in_read got rd=%b want 1", rd); else pass_cnt++;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (rd !== 1'b0) $display("FAIL rstmid_rd got %b want 0", rd); else pass_cnt++;
        repeat (8) @(negedge clk);
        @(posedge clk); #1;
        rd_wait = 0;
        total_cnt++; if (done_cnt - d0 !== 0) $display("FAIL rstmid_no_done got %0d done cycles want 0", done_cnt - d0); else pass_cnt++;
        total_cnt++; if (mem[32'h100] !== 32'h11223344) $display("FAIL rstmid_mem got %h want 11223344", mem[32'h100]); else pass_cnt++;
        @(negedge clk);
        do_store(32'h108, 32'h12345678, 2'b10, 0, lat, e);
        @(posedge clk); #1;
        total_cnt++; if (lat !== 2) $display("FAIL rstmid_word_latency got %0d want 2", lat); else pass_cnt++;
        total_cnt++; if (mem[32'h108] !== 32'h12345678) $display("FAIL rstmid_word_mem got %h want 12345678", mem[32'h108]); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int lat1, lat2; logic e;
        @(negedge clk);
        do_store(32'h10C, 32'h01020304, 2'b10, 0, lat1, e);
        @(negedge clk);
        total_cnt++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL b2b_gap got busy=%b done=%b want 0 0", busy, done); else pass_cnt++;
        do_store(32'h110, 32'hA5A5A5A5, 2'b10, 0, lat2, e);
        @(posedge clk); #1;
        total_cnt++; if (lat1 !== 2) $display("FAIL b2b_lat1 got %0d want 2", lat1); else pass_cnt++;
        total_cnt++; if (lat2 !== 2) $display("FAIL b2b_lat2 got %0d want 2", lat2); else pass_cnt++;
        total_cnt++; if (mem[32'h10C] !== 32'h01020304) $display("FAIL b2b_mem1 got %h want 01020304", mem[32'h10C]); else pass_cnt++;
        total_cnt++; if (mem[32'h110] !== 32'hA5A5A5A5) $display("FAIL b2b_mem2 got %h want a5a5a5a5", mem[32'h110]); else pass_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.i_StoreNarrow_start = 1'b0;
        bus.i_StoreNarrow_addr  = '0;
        bus.i_StoreNarrow_data  = '0;
        bus.i_StoreNarrow_size  = '0;
        test_reset();
        test_byte();
        test_half();
        test_word();
        test_errors();
        test_wait();
        test_reset_mid();
        test_back_to_back();
        total_cnt++; if (overlap !== 0) $display("FAIL rd_wr_overlap got %0d cycles want 0", overlap); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/store_narrow.md
Name: store_narrow

Overview:
Multi-cycle store unit for the MultiCPU datapath. It narrows a 32-bit register value to byte, halfword or word width and places it into the correct lanes of word-addressed data memory. Byte and halfword stores use a read-modify-write sequence. The block is the store-side counterpart of the load path's sign/zero number extension. It sits between the execute/MEM control FSM and data memory.

Parameters:
ADDR_W, 32, byte-address width
DATA_W, 32, memory word width (fixed 32; lane logic assumes 4 bytes)

Ports:
i_StoreNarrow_clk  in  1  clock, rising edge
i_StoreNarrow_rst_n  in  1  synchronous reset, active-low
i_StoreNarrow_start  in  1  request strobe; sampled only in IDLE
i_StoreNarrow_addr  in  ADDR_W  byte address
i_StoreNarrow_data  in  32  register value; low bits are stored
i_StoreNarrow_size  in  2  00 byte, 01 half, 10 word, 11 illegal
o_StoreNarrow_busy  out  1  high in every state except IDLE
o_StoreNarrow_done  out  1  one-cycle completion pulse
o_StoreNarrow_err  out  1  high with done on misaligned/illegal request
o_StoreNarrow_mem_addr  out  ADDR_W  word address, bits[1:0] = 0
o_StoreNarrow_mem_rd  out  1  read request, held until ack
o_StoreNarrow_mem_wr  out  1  write request, held until ack
o_StoreNarrow_mem_wdata  out  32  merged write word
i_StoreNarrow_mem_rdata  in  32  read data, valid in ack cycle
i_StoreNarrow_mem_ack  in  1  memory completes the current rd/wr this cycle

Behaviour:
- Reset (rst_n low at a clock edge): state=IDLE. busy, done, err, mem_rd and mem_wr are 0. mem_addr and mem_wdata are 0. Internal latches are cleared. Reset mid-operation abandons the access; rd/wr drop at that edge and no done is issued.
- Accept: in IDLE with start=1, latch addr, data and size. start outside IDLE is ignored and not queued.
- Lane mapping is little-endian:
  - byte k = addr[1:0] occupies bits 8k+7:8k
  - half: addr[1]=0 occupies bits 15:0, addr[1]=1 occupies bits 31:16
  - the stored value is data[7:0] for byte, data[15:0] for half, data[31:0] for word
- Error check at accept: err if size=11, or half with addr[0]=1, or word with addr[1:0]!=0. On error, go to DONE next cycle with err=1 and no memory access.
- States:
  - IDLE -> READ (byte/half) | WRITE (word) | DONE (error)
  - READ: mem_rd=1, mem_addr={addr[ADDR_W-1:2],2'b00}. On ack, capture rdata -> MERGE.
  - MERGE: one cycle. wdata_reg = rdata with only the selected lanes replaced -> WRITE.
  - WRITE: mem_wr=1, mem_wdata=wdata_reg (word store: data). On ack -> DONE.
  - DONE: done=1 for exactly one cycle, err as latched -> IDLE.
- rd and wr are never high together. Outputs are stable while a request is waiting for ack.
- Latency from the start edge to the done cycle, with zero-wait ack (ack in the first request cycle):
  - word: 2 cycles
  - byte/half: 4 cycles
  - error: 1 cycle
  - each additional wait cycle on ack adds 1.
- A new start is accepted in the IDLE cycle after DONE, so back-to-back stores are separated by one IDLE cycle.

Test Plan:
- Memory word at 0x100 = 0x11223344; byte store data=0xAABBCCDD, addr=0x101, immediate ack -> one read of 0x100, then write 0x1122DD44; done 4 cycles after start, err=0.
- Half store data=0x0000BEEF, addr=0x102, on word 0x11223344 -> write 0xBEEF3344; lanes 0-1 unchanged.
- Word store data=0xDEADBEEF, addr=0x104 -> no rd pulse; wr with wdata 0xDEADBEEF to 0x104; done 2 cycles after start.
- Error requests: half addr=0x103, word addr=0x106, size=11 -> done=err=1 one cycle after start; mem_rd/mem_wr never asserted.
- ack held low 3 cycles in READ and 2 in WRITE -> rd/wr and addr stay stable throughout; byte latency = 9 cycles; start pulses while busy are ignored.
- rst_n low for one cycle while in READ -> next cycle IDLE with busy=0, rd=0, no done; a following word store completes normally.
